// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM power-up sequencer: command pins, Gray-coded states,
// mode-register fields and default timing.
package sdram_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

  localparam logic [1:0]  BANK_ALL = 2'b11;
  localparam logic [12:0] ADDR_ALL = 13'h1FFF;

  // Gray sequence: every legal transition flips a single bit
  typedef enum logic [2:0] {
    INIT_WAIT = 3'b000,
    INIT_PRE  = 3'b001,
    INIT_TRP  = 3'b011,
    INIT_AR   = 3'b010,
    INIT_TRFC = 3'b110,
    INIT_MRS  = 3'b111,
    INIT_TMRD = 3'b101,
    INIT_END  = 3'b100
  } init_state_e;

  localparam logic       MR_WRITE_BURST = 1'b0;
  localparam logic [2:0] MR_CAS_LAT3    = 3'd3;
  localparam logic       MR_BURST_SEQ   = 1'b0;
  localparam logic [2:0] MR_BURST_FULL  = 3'b111;
  localparam logic [12:0] MR_DEFAULT =
    {3'b000, MR_WRITE_BURST, 2'b00, MR_CAS_LAT3, MR_BURST_SEQ, MR_BURST_FULL};

  localparam int unsigned T_POWER_DEF   = 10000;
  localparam int unsigned T_POWER_FAST  = 200;
  localparam int unsigned TRP_CLK_DEF   = 2;
  localparam int unsigned TRFC_CLK_DEF  = 7;
  localparam int unsigned TMRD_CLK_DEF  = 3;
  localparam int unsigned AR_NUM_DEF    = 8;

endpackage

// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up sequencer: wait, PRECHARGE ALL, AUTO REFRESH x AR_NUM, LOAD MODE, then init_end.
// Define SDRAM_INIT_FAST_SIM_EN to shorten the power-up wait to 200 clocks.
module sdram_init_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned  T_POWER  = T_POWER_DEF,
  parameter int unsigned  TRP_CLK  = TRP_CLK_DEF,
  parameter int unsigned  TRFC_CLK = TRFC_CLK_DEF,
  parameter int unsigned  TMRD_CLK = TMRD_CLK_DEF,
  parameter int unsigned  AR_NUM   = AR_NUM_DEF,
  parameter logic [12:0]  MR_VALUE = MR_DEFAULT
) (
  input  logic        init_clk,
  input  logic        init_rst_n,
  output logic [3:0]  init_cmd,
  output logic [1:0]  init_bank,
  output logic [12:0] init_addr,
  output logic        init_end
);

`ifdef SDRAM_INIT_FAST_SIM_EN
  localparam int unsigned POWER_WAIT = T_POWER_FAST;
`else
  localparam int unsigned POWER_WAIT = T_POWER;
`endif

  localparam logic [13:0] PWR_LAST  = 14'(POWER_WAIT - 1);
  localparam logic [3:0]  TRP_LAST  = 4'(TRP_CLK - 1);
  localparam logic [3:0]  TRFC_LAST = 4'(TRFC_CLK - 1);
  localparam logic [3:0]  TMRD_LAST = 4'(TMRD_CLK - 1);
  localparam logic [3:0]  AR_TOTAL  = 4'(AR_NUM);

  init_state_e state_cur, state_d;
  logic [13:0] pwr_cnt_q, pwr_cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  ar_cnt_q, ar_cnt_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  bank_q, bank_d;
  logic [12:0] addr_q, addr_d;
  logic        end_q, end_d;

  always_comb begin
    state_d    = state_cur;
    pwr_cnt_d  = pwr_cnt_q;
    wait_cnt_d = '0;  // one-cycle states clear it, so each timed state starts at 0
    ar_cnt_d   = ar_cnt_q;

    case (state_cur)
      INIT_WAIT: begin
        if (pwr_cnt_q == PWR_LAST) state_d = INIT_PRE;
        else                       pwr_cnt_d = pwr_cnt_q + 14'd1;
      end
      INIT_PRE: state_d = INIT_TRP;
      INIT_TRP: begin
        if (wait_cnt_q == TRP_LAST) state_d = INIT_AR;
        else                        wait_cnt_d = wait_cnt_q + 4'd1;
      end
      INIT_AR: begin
        state_d = INIT_TRFC;
        if (ar_cnt_q != 4'hF) ar_cnt_d = ar_cnt_q + 4'd1;
      end
      INIT_TRFC: begin
        if (wait_cnt_q == TRFC_LAST) state_d = (ar_cnt_q < AR_TOTAL) ? INIT_AR : INIT_MRS;
        else                         wait_cnt_d = wait_cnt_q + 4'd1;
      end
      INIT_MRS: state_d = INIT_TMRD;
      INIT_TMRD: begin
        if (wait_cnt_q == TMRD_LAST) state_d = INIT_END;
        else                         wait_cnt_d = wait_cnt_q + 4'd1;
      end
      INIT_END: state_d = INIT_END;
      default:  state_d = INIT_WAIT;
    endcase

    // Decode from the next state so the pins change on the same edge as state_cur
    cmd_d  = CMD_NOP;
    bank_d = BANK_ALL;
    addr_d = ADDR_ALL;
    case (state_d)
      INIT_PRE: cmd_d = CMD_PRECHARGE;
      INIT_AR:  cmd_d = CMD_AUTO_REFRESH;
      INIT_MRS: begin
        cmd_d  = CMD_LOAD_MODE;
        bank_d = 2'b00;
        addr_d = MR_VALUE;
      end
      default: ;
    endcase
    end_d = (state_d == INIT_END);
  end

  always_ff @(posedge init_clk or negedge init_rst_n) begin
    if (!init_rst_n) begin
      state_cur  <= INIT_WAIT;
      pwr_cnt_q  <= '0;
      wait_cnt_q <= '0;
      ar_cnt_q   <= '0;
      cmd_q      <= CMD_NOP;
      bank_q     <= BANK_ALL;
      addr_q     <= ADDR_ALL;
      end_q      <= 1'b0;
    end else begin
      state_cur  <= state_d;
      pwr_cnt_q  <= pwr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      ar_cnt_q   <= ar_cnt_d;
      cmd_q      <= cmd_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      end_q      <= end_d;
    end
  end

  assign init_cmd  = cmd_q;
  assign init_bank = bank_q;
  assign init_addr = addr_q;
  assign init_end  = end_q;

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Scoreboard bench for sdram_init_ctrl: expected commands are queued per run, a negedge
// monitor pops them as non-NOP commands appear and checks idle bus and init_end every cycle.
module tb_sdram_init_ctrl;

`ifdef SDRAM_INIT_FAST_SIM_EN
  localparam int TP = 200;
`else
  localparam int TP = 10000;
`endif
  localparam int NEVER = 1 << 30;

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
    logic [1:0] bank;
    logic [12:0] addr;
  } exp_t;

  logic        init_clk = 1'b0;
  logic        init_rst_n = 1'b0;
  logic [3:0]  init_cmd;
  logic [1:0]  init_bank;
  logic [12:0] init_addr;
  logic        init_end;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int end_cyc = NEVER;
  int ar_seen = 0;

  sdram_init_ctrl dut (
    .init_clk  (init_clk),
    .init_rst_n(init_rst_n),
    .init_cmd  (init_cmd),
    .init_bank (init_bank),
    .init_addr (init_addr),
    .init_end  (init_end)
  );

  always #5 init_clk = ~init_clk;

  task automatic push_seq();
    exp_q.push_back('{TP, 4'b0010, 2'b11, 13'h1FFF});
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{TP + 3 + 8 * i, 4'b0001, 2'b11, 13'h1FFF});
    exp_q.push_back('{TP + 67, 4'b0000, 2'b00, 13'h037});
    end_cyc = TP + 71;
  endtask

  task automatic check_idle(input string tag);
    total++;
    if (init_cmd !== 4'b0111 || init_bank !== 2'b11 || init_addr !== 13'h1FFF || init_end !== 1'b0) begin
      bad++;
      $display("FAIL %s: got cmd=%b bank=%b addr=%h end=%b, want cmd=0111 bank=11 addr=1fff end=0",
               tag, init_cmd, init_bank, init_addr, init_end);
    end
  endtask

  task automatic check_count(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic sample();
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_cmd: cmd %b expected at cycle %0d not seen (now cycle %0d)",
               exp_q[0].cmd, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    total++;
    if (init_cmd !== 4'b0111) begin
      if (init_cmd === 4'b0001) ar_seen++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_cmd: got cmd=%b at cycle %0d, want NOP", init_cmd, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.cmd !== init_cmd || e.bank !== init_bank || e.addr !== init_addr) begin
          bad++;
          $display("FAIL cmd_match: got cyc=%0d cmd=%b bank=%b addr=%h, want cyc=%0d cmd=%b bank=%b addr=%h",
                   cyc, init_cmd, init_bank, init_addr, e.cyc, e.cmd, e.bank, e.addr);
        end
      end
      if (init_cmd === 4'b0000) begin
        total++;
        if (init_addr[6:4] !== 3'd3) begin
          bad++;
          $display("FAIL mr_cas_latency: got %0d, want 3", init_addr[6:4]);
        end
        total++;
        if (init_addr[2:0] !== 3'b111) begin
          bad++;
          $display("FAIL mr_burst_len: got %b, want 111 (full page)", init_addr[2:0]);
        end
      end
    end else if (init_bank !== 2'b11 || init_addr !== 13'h1FFF) begin
      bad++;
      $display("FAIL nop_bus: cycle %0d got bank=%b addr=%h, want bank=11 addr=1fff",
               cyc, init_bank, init_addr);
    end
    total++;
    if (init_end !== (cyc >= end_cyc)) begin
      bad++;
      $display("FAIL init_end: cycle %0d got %b, want %b", cyc, init_end, (cyc >= end_cyc));
    end
  endtask

  // Monitor: cycle n is what the bus holds just before the n-th rising edge after release
  initial begin
    forever begin
      @(negedge init_clk);
      #1;
      if (!init_rst_n) cyc = 0;
      else begin
        sample();
        cyc++;
      end
    end
  end

  initial begin
    #100;
    check_idle("reset_state");
    repeat (20) @(negedge init_clk);
    push_seq();
    init_rst_n = 1'b1;

    // Full sequence plus a long idle tail
    repeat (TP + 71 + 1000) @(negedge init_clk);
    #2;
    check_count("run1_pending_cmds", exp_q.size(), 0);
    check_count("run1_ar_count", ar_seen, 8);

    init_rst_n = 1'b0;
    exp_q.delete();
    end_cyc = NEVER;
    ar_seen = 0;
    repeat (3) @(negedge init_clk);
    push_seq();
    init_rst_n = 1'b1;

    // Abort during the third AUTO_REFRESH
    repeat (TP + 19) @(negedge init_clk);
    #3;
    check_count("run2_ar_before_abort", ar_seen, 3);
    init_rst_n = 1'b0;
    #1;
    check_idle("async_reset_mid_ar");
    exp_q.delete();
    end_cyc = NEVER;
    ar_seen = 0;
    repeat (3) @(negedge init_clk);
    check_idle("reset_held");
    push_seq();
    init_rst_n = 1'b1;

    repeat (TP + 71 + 20) @(negedge init_clk);
    #2;
    check_count("run3_pending_cmds", exp_q.size(), 0);
    check_count("run3_ar_count", ar_seen, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
